// File: rtl/rate_key_pkg.sv
// Shared constants, key FSM state type and ms-to-cycles helper for the
// rate_key_ctrl push-button front end.
package rate_key_pkg;

   localparam logic [1:0] RATE_1HZ  = 2'b00;
   localparam logic [1:0] RATE_5HZ  = 2'b01;
   localparam logic [1:0] RATE_10HZ = 2'b11;

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } key_state_t;

   // Integer division first, so CLOCKFREQ below 1 kHz truncates to zero cycles
   // per ms and is caught by the elaboration check in key_debounce.
   function automatic logic [31:0] ms_to_cycles(input int unsigned freq, input int unsigned ms);
      return freq / 32'd1000 * ms;
   endfunction

endpackage

// File: rtl/rate_key_ctrl_key_debounce.sv
// key_debounce: 2-flop synchroniser, press/release debounce FSM and a one-cycle
// accept pulse per debounced press. With RATE_HOLD_REPEAT_EN defined, a
// repeat down-counter adds extra accept pulses while the key stays pressed.
//
// state        | meaning
// -------------+--------------------------------------------------------
// RELEASED     | key debounced as up, waiting for a low sample
// PRESS_WAIT   | counting consecutive low samples towards D
// PRESSED      | key debounced as down (accept already issued)
// RELEASE_WAIT | counting consecutive high samples towards D
module key_debounce
   import rate_key_pkg::*;
#(
   parameter int unsigned CLOCKFREQ        = 100_000_000,
   parameter int unsigned DEBOUNCE_MS      = 20,
   parameter int unsigned REPEAT_DELAY_MS  = 500,
   parameter int unsigned REPEAT_PERIOD_MS = 250
) (
   input  logic iClk,
   input  logic iRst_n,
   input  logic iKey_n,
   output logic oAccept
);

   localparam logic [31:0] D_C = ms_to_cycles(CLOCKFREQ, DEBOUNCE_MS);

   if (D_C < 32'd1) begin : g_bad_debounce
      $error("key_debounce: CLOCKFREQ/1000*DEBOUNCE_MS must be at least 1");
   end

   logic        sync1_q, sync2_q;
   key_state_t  state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic        deb_acc;

   // Two-flop synchroniser; resets to the released level.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= iKey_n;
         sync2_q <= sync1_q;
      end
   end

   // Debounce FSM next state; with D = 1 the single qualifying sample jumps
   // straight across the wait state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      deb_acc = 1'b0;
      case (state_q)
         RELEASED: begin
            if (!sync2_q) begin
               if (D_C == 32'd1) begin
                  state_d = PRESSED;
                  cnt_d   = '0;
                  deb_acc = 1'b1;
               end else begin
                  state_d = PRESS_WAIT;
                  cnt_d   = 32'd1;
               end
            end
         end
         PRESS_WAIT: begin
            if (sync2_q) begin
               state_d = RELEASED;
               cnt_d   = '0;
            end else if (cnt_q + 32'd1 == D_C) begin
               state_d = PRESSED;
               cnt_d   = '0;
               deb_acc = 1'b1;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         PRESSED: begin
            if (sync2_q) begin
               if (D_C == 32'd1) begin
                  state_d = RELEASED;
                  cnt_d   = '0;
               end else begin
                  state_d = RELEASE_WAIT;
                  cnt_d   = 32'd1;
               end
            end
         end
         RELEASE_WAIT: begin
            if (!sync2_q) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q + 32'd1 == D_C) begin
               state_d = RELEASED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         default: begin
            state_d = RELEASED;
            cnt_d   = '0;
         end
      endcase
   end

   // FSM state and debounce counter registers.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q <= RELEASED;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef RATE_HOLD_REPEAT_EN
   localparam logic [31:0] RD_C = ms_to_cycles(CLOCKFREQ, REPEAT_DELAY_MS);
   localparam logic [31:0] RP_C = ms_to_cycles(CLOCKFREQ, REPEAT_PERIOD_MS);

   if (RD_C < 32'd1 || RP_C < 32'd1) begin : g_bad_repeat
      $error("key_debounce: repeat delay and period must each be at least 1 cycle");
   end

   logic [31:0] rpt_q, rpt_d;
   logic        rpt_fire;

   // Repeat timer: loaded on entry to PRESSED, fires at terminal count and
   // reloads with the period; cleared whenever the key is not held in PRESSED.
   always_comb begin
      rpt_d    = rpt_q;
      rpt_fire = 1'b0;
      if (state_d != PRESSED) begin
         rpt_d = '0;
      end else if (state_q != PRESSED) begin
         rpt_d = RD_C - 32'd1;
      end else if (rpt_q == '0) begin
         rpt_fire = 1'b1;
         rpt_d    = RP_C - 32'd1;
      end else begin
         rpt_d = rpt_q - 32'd1;
      end
   end

   // Repeat timer register.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         rpt_q <= '0;
      end else begin
         rpt_q <= rpt_d;
      end
   end

   assign oAccept = deb_acc | rpt_fire;
`else
   // Repeat timing is accepted as parameters but no repeat hardware is built.
   if (REPEAT_DELAY_MS == 0 && REPEAT_PERIOD_MS == 0) begin : g_repeat_unused
   end

   assign oAccept = deb_acc;
`endif

endmodule

// File: rtl/rate_key_ctrl.sv
// rate_key_ctrl: debounced up/down keys step a 2-bit LED rate code through
// 1 Hz -> 5 Hz -> 10 Hz (wrapping) with a one-cycle change strobe.
// Optional hold-to-repeat stepping is built when RATE_HOLD_REPEAT_EN is defined.
module rate_key_ctrl
   import rate_key_pkg::*;
#(
   parameter int unsigned CLOCKFREQ        = 100_000_000,
   parameter int unsigned DEBOUNCE_MS      = 20,
   parameter int unsigned REPEAT_DELAY_MS  = 500,
   parameter int unsigned REPEAT_PERIOD_MS = 250
) (
   input  logic       iClk,
   input  logic       iRSt_n,
   input  logic       iKey_up_n,
   input  logic       iKey_dn_n,
   output logic [1:0] oRate_control,
   output logic       oChange
);

   logic       acc_up, acc_dn;
   logic [1:0] rate_q, rate_d;
   logic       change_q, change_d;

   key_debounce #(
      .CLOCKFREQ       (CLOCKFREQ),
      .DEBOUNCE_MS     (DEBOUNCE_MS),
      .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
      .REPEAT_PERIOD_MS(REPEAT_PERIOD_MS)
   ) u_key_up (
      .iClk   (iClk),
      .iRst_n (iRSt_n),
      .iKey_n (iKey_up_n),
      .oAccept(acc_up)
   );

   key_debounce #(
      .CLOCKFREQ       (CLOCKFREQ),
      .DEBOUNCE_MS     (DEBOUNCE_MS),
      .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
      .REPEAT_PERIOD_MS(REPEAT_PERIOD_MS)
   ) u_key_dn (
      .iClk   (iClk),
      .iRst_n (iRSt_n),
      .iKey_n (iKey_dn_n),
      .oAccept(acc_dn)
   );

   // Step the rate code on a lone accept; simultaneous accepts cancel, and the
   // unused code 10 is recovered to 1 Hz.
   always_comb begin
      rate_d   = rate_q;
      change_d = 1'b0;
      if (rate_q == 2'b10) begin
         rate_d   = RATE_1HZ;
         change_d = 1'b1;
      end else if (acc_up && !acc_dn) begin
         case (rate_q)
            RATE_1HZ: rate_d = RATE_5HZ;
            RATE_5HZ: rate_d = RATE_10HZ;
            default:  rate_d = RATE_1HZ;
         endcase
         change_d = 1'b1;
      end else if (acc_dn && !acc_up) begin
         case (rate_q)
            RATE_1HZ:  rate_d = RATE_10HZ;
            RATE_10HZ: rate_d = RATE_5HZ;
            default:   rate_d = RATE_1HZ;
         endcase
         change_d = 1'b1;
      end
   end

   // Registered rate code and change strobe.
   always_ff @(posedge iClk or negedge iRSt_n) begin
      if (!iRSt_n) begin
         rate_q   <= RATE_1HZ;
         change_q <= 1'b0;
      end else begin
         rate_q   <= rate_d;
         change_q <= change_d;
      end
   end

   assign oRate_control = rate_q;
   assign oChange       = change_q;

endmodule

// File: tb/tb_rate_key_ctrl.sv
// Testbench for rate_key_ctrl (default build, repeat feature off), with
// CLOCKFREQ=1000 and DEBOUNCE_MS=4 so the debounce length is 4 cycles.
module tb_rate_key_ctrl;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_up = 1'b1;
   logic       key_dn = 1'b1;
   logic [1:0] rate;
   logic       chg;

   int n_cmp = 0;
   int n_bad = 0;
   int n_chg = 0;
   int cyc   = 0;

   rate_key_ctrl #(
      .CLOCKFREQ       (1000),
      .DEBOUNCE_MS     (4),
      .REPEAT_DELAY_MS (10),
      .REPEAT_PERIOD_MS(5)
   ) dut (
      .iClk         (clk),
      .iRSt_n       (rst_n),
      .iKey_up_n    (key_up),
      .iKey_dn_n    (key_dn),
      .oRate_control(rate),
      .oChange      (chg)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      logic [1:0] rate;
      int         cyc;
   } exp_t;

   exp_t       exp_q[$];
   logic [1:0] code_tab [3] = '{2'b00, 2'b01, 2'b11};
   int         m_idx = 0;
   logic       m_d1 [2] = '{1'b1, 1'b1};
   logic       m_d2 [2] = '{1'b1, 1'b1};
   logic       m_pressed [2] = '{1'b0, 1'b0};
   int         m_run [2] = '{0, 0};
   logic       m_raw [2];
   logic       m_acc [2];
   logic       m_use;

   // A key's debounced level flips after D consecutive synchronised samples
   // that disagree with it; each flip to "pressed" is one step request.
   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_d1[k] = 1'b1; m_d2[k] = 1'b1; m_pressed[k] = 1'b0; m_run[k] = 0;
         end
         m_idx = 0;
         exp_q.delete();
      end else begin
         m_raw[0] = key_up;
         m_raw[1] = key_dn;
         for (int k = 0; k < 2; k++) begin
            m_use   = m_d2[k];
            m_d2[k] = m_d1[k];
            m_d1[k] = m_raw[k];
            m_acc[k] = 1'b0;
            if (m_use == m_pressed[k]) m_run[k]++;
            else m_run[k] = 0;
            if (m_run[k] == D) begin
               m_pressed[k] = ~m_pressed[k];
               m_run[k]     = 0;
               m_acc[k]     = m_pressed[k];
            end
         end
         if (m_acc[0] != m_acc[1]) begin
            m_idx = m_acc[0] ? (m_idx + 1) % 3 : (m_idx + 2) % 3;
            exp_q.push_back('{code_tab[m_idx], cyc});
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   exp_t e;
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         e = exp_q.pop_front();
         n_cmp++; n_bad++;
         $display("FAIL missed_change: no strobe seen, wanted rate %b at cycle %0d", e.rate, e.cyc);
      end
      if (rst_n && chg) begin
         n_chg++;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_change: got strobe with rate %b at cycle %0d, none wanted", rate, cyc);
         end else begin
            e = exp_q.pop_front();
            if (rate !== e.rate || cyc != e.cyc) begin
               n_bad++;
               $display("FAIL change_value: got rate %b at cycle %0d, want rate %b at cycle %0d",
                        rate, cyc, e.rate, e.cyc);
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, want %b", nm, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   task automatic keys(input logic u, input logic d, input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
         key_up = u;
         key_dn = d;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      rst_n  = 1'b0;
      key_up = 1'b1;
      key_dn = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("reset_rate", rate, 2'b00);
         chk("reset_change", {1'b0, chg}, 2'b00);
      end
      #1;
      rst_n = 1'b1;
   endtask

   logic [1:0] up_seq [3] = '{2'b01, 2'b11, 2'b00};
   logic [1:0] dn_seq [3] = '{2'b11, 2'b01, 2'b00};
   int n0;

   initial begin
      // Power-on reset
      repeat (3) @(negedge clk);
      chk("por_rate", rate, 2'b00);
      chk("por_change", {1'b0, chg}, 2'b00);
      #1;
      rst_n = 1'b1;
      keys(1, 1, 4);

      // Hold up from edge 0: step at edge 1+D, one-cycle strobe, no repeat
      do_reset();
      n0 = n_chg;
      @(negedge clk);
      #1;
      key_up = 1'b0;
      repeat (D + 1) @(posedge clk);
      @(negedge clk);
      chk("hold_before_step", rate, 2'b00);
      @(posedge clk);
      @(negedge clk);
      chk("hold_step_rate", rate, 2'b01);
      chk("hold_step_change", {1'b0, chg}, 2'b01);
      @(negedge clk);
      chk("hold_change_drop", {1'b0, chg}, 2'b00);
      keys(0, 1, 25);
      chk("hold_rate_stays", rate, 2'b01);
      chk_int("hold_strobe_count", n_chg - n0, 1);
      keys(1, 1, 12);

      // Clean presses up then down
      do_reset();
      for (int i = 0; i < 3; i++) begin
         keys(0, 1, 8);
         keys(1, 1, 10);
         chk("up_press", rate, up_seq[i]);
      end
      for (int i = 0; i < 3; i++) begin
         keys(1, 0, 8);
         keys(1, 1, 10);
         chk("dn_press", rate, dn_seq[i]);
      end

      // Bounce rejected, then a D-cycle press accepted
      do_reset();
      keys(0, 1, 3);
      keys(1, 1, 1);
      keys(0, 1, 3);
      keys(1, 1, 8);
      chk("bounce_rejected", rate, 2'b00);
      keys(0, 1, D);
      keys(1, 1, 10);
      chk("exact_d_press", rate, 2'b01);

      // Both keys together cancel
      do_reset();
      n0 = n_chg;
      keys(0, 0, 20);
      chk("both_rate", rate, 2'b00);
      chk_int("both_strobes", n_chg - n0, 0);
      keys(1, 1, 12);

      // Reset mid PRESS_WAIT, released with key still held
      do_reset();
      @(negedge clk);
      #1;
      key_up = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("midrst_rate", rate, 2'b00);
      end
      #1;
      rst_n = 1'b1;
      repeat (D + 1) @(posedge clk);
      @(negedge clk);
      chk("midrst_before_step", rate, 2'b00);
      @(posedge clk);
      @(negedge clk);
      chk("midrst_step", rate, 2'b01);
      keys(1, 1, 12);

      // Randomised key chatter and occasional reset, checked by scoreboard
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         #1;
         if (!rst_n) rst_n = 1'b1;
         else if ($urandom_range(599) == 0) rst_n = 1'b0;
         if ($urandom_range(6) == 0) key_up = ~key_up;
         if ($urandom_range(6) == 0) key_dn = ~key_dn;
      end
      #1;
      rst_n = 1'b1;
      keys(1, 1, 15);
      chk_int("queue_drained", exp_q.size(), 0);
      chk("final_rate", rate, code_tab[m_idx]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rate_key_ctrl.md
# rate_key_ctrl

Push-button front end for the LED rate divider. It synchronises and debounces two active-low keys (up/down). It steps a 2-bit rate code through the legal set 1 Hz → 5 Hz → 10 Hz and drives the divider's rate-control input directly, with a one-cycle change strobe for status logic.

## Interface
- CLOCKFREQ, 100_000_000: iClk frequency in Hz.
- DEBOUNCE_MS, 20: stable time required to accept a press or release.
- REPEAT_DELAY_MS, 500: hold time before the first auto-repeat step (only with RATE_HOLD_REPEAT_EN).
- REPEAT_PERIOD_MS, 250: interval between auto-repeat steps (only with RATE_HOLD_REPEAT_EN).
- iClk  input  1  system clock.
- iRSt_n  input  1  reset; one clock; reset is asynchronous and active-low.
- iKey_up_n  input  1  raw "faster" key, active-low, asynchronous to iClk.
- iKey_dn_n  input  1  raw "slower" key, active-low, asynchronous to iClk.
- oRate_control  output  2  rate code: 00 = 1 Hz, 01 = 5 Hz, 11 = 10 Hz. The code 10 is never driven.
- oChange  output  1  one-cycle pulse in the cycle oRate_control takes a new value.

## Operation
- Each key goes through a 2-flop synchroniser. Both flops reset to 1 (released).
- Derived constant: D = CLOCKFREQ/1000*DEBOUNCE_MS, computed at elaboration. D ≥ 1 is required (elaboration error otherwise). Counters are 32 bits.
- Per-key FSM with four states:
  - RELEASED: on a synchronised low sample, go to PRESS_WAIT and set the counter to 1.
  - PRESS_WAIT: each low sample increments the counter. The sample that makes the count equal D goes to PRESSED and emits a 1-cycle accept pulse. Any high sample returns to RELEASED and clears the counter.
  - PRESSED: on a high sample, go to RELEASE_WAIT with the counter set to 1.
  - RELEASE_WAIT: symmetric to PRESS_WAIT. D consecutive high samples go to RELEASED with no pulse. Any low sample returns to PRESSED.
- Rate stepping on accept pulses:
  - up: 00→01→11→00 (wraps).
  - down: 00→11→01→00 (wraps).
- Both accept pulses in the same cycle: no change and no oChange.
- If oRate_control ever holds 10, it is forced to 00 on the next cycle and oChange pulses.
- Only accept pulses move the code. Holding a key gives exactly one step, unless the configuration feature below is enabled.

## Timing
- Reset (async assert) values:
  - oRate_control = 00, oChange = 0.
  - Both FSMs in RELEASED, counters 0, synchronisers 1.
- Release is synchronous to iClk. Outputs are registered.
- Latency: the raw key is first sampled low at edge 0. The synchronised low is visible after edge 1. oRate_control and oChange update at edge 1+D if the key stays low, and oChange drops at edge 2+D.
- Minimum press-to-press spacing is 2·D cycles plus synchroniser delay. Faster chatter is rejected.
- Reset asserted mid-debounce discards the partial count. After release, a key that is still held is treated as a new press, which costs a full D cycles.

## Configuration
- RATE_HOLD_REPEAT_EN defined:
  - While a key stays in PRESSED, a per-key repeat counter issues extra accept pulses.
  - The first extra pulse comes CLOCKFREQ/1000*REPEAT_DELAY_MS cycles after entering PRESSED. Later pulses come every CLOCKFREQ/1000*REPEAT_PERIOD_MS cycles.
  - The repeat counter clears on leaving PRESSED, including entry into RELEASE_WAIT.
  - Simultaneous up and down repeat pulses cancel, as above.
- Undefined: no repeat logic is built. The REPEAT_* parameters are present but unused.

## Structure
- Package rate_key_pkg holds:
  - Constants RATE_1HZ = 2'b00, RATE_5HZ = 2'b01, RATE_10HZ = 2'b11.
  - Enum key_state_t {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT}.
  - Function ms_to_cycles(freq, ms).
- Sub-module key_debounce contains the synchroniser, FSM, debounce counter and optional repeat counter, and outputs an accept pulse. It is instantiated twice.
- The top level holds only the stepping logic and output registers.

## Test plan
All scenarios use CLOCKFREQ=1000 and DEBOUNCE_MS=4, so D = 4.
- Reset, then hold iKey_up_n low from edge 0 → oRate_control 00→01 at edge 5, oChange high for exactly one cycle, and no further change while held.
- Three clean up presses from 00 → 01, 11, 00. Three clean down presses from 00 → 11, 01, 00.
- Up key low for 3 cycles, high 1, low 3 (bounce) → no change. A following 4-cycle low → a single step.
- Both keys pressed at the same edge and held → oRate_control stays 00 and oChange never asserts.
- iRSt_n asserted 2 cycles into PRESS_WAIT, then released with the key still low → oRate_control 00 during reset. The step happens at 1+4 edges after release.
- With RATE_HOLD_REPEAT_EN, REPEAT_DELAY_MS=10 and REPEAT_PERIOD_MS=5, up held for 30 cycles → steps at edges 5, 15, 20, 25, 30, giving codes 01, 11, 00, 01, 11.
